// File: rtl/pmci_spi_bridge_pkg.sv
// Shared register offsets, SPI_CSR bit positions and FSM encoding for the PMCI SPI bridge.
package pmci_spi_bridge_pkg;

   localparam int unsigned CSR_AW = 4;
   localparam int unsigned CSR_DW = 32;

   // Byte offsets; only [3:2] take part in the decode
   localparam logic [CSR_AW-1:0] SPI_CSR_OFS   = 4'h0;
   localparam logic [CSR_AW-1:0] SPI_AR_OFS    = 4'h4;
   localparam logic [CSR_AW-1:0] SPI_RD_DR_OFS = 4'h8;
   localparam logic [CSR_AW-1:0] SPI_WR_DR_OFS = 4'hC;

   localparam int unsigned CSR_RD_CMD = 0;
   localparam int unsigned CSR_WR_CMD = 1;
   localparam int unsigned CSR_ERR    = 2;
   localparam int unsigned CSR_BUSY   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_RDW  = 2'd3
   } state_e;

endpackage

// File: rtl/pmci_spi_bridge_tmo.sv
// Per-transaction watchdog: cleared on transaction start, counts while busy,
// flags the last allowed cycle. Present only with PMCI_SPI_BRIDGE_TIMEOUT_EN.
module pmci_spi_bridge_tmo #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic run,
   output logic expired_c
);
   localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   assign expired_c = run && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt <= '0;
      else if (start)              cnt <= '0;
      else if (run && !expired_c)  cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/pmci_spi_bridge.sv
// CSR window (SPI_CSR/AR/RD_DR/WR_DR) driving a single-outstanding Avalon-MM master.
// Define PMCI_SPI_BRIDGE_TIMEOUT_EN to add the transaction watchdog and sticky ERR flag.
module pmci_spi_bridge
   import pmci_spi_bridge_pkg::*;
#(
   parameter int unsigned AVMM_AW     = 20,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               csr_wr,
   input  logic               csr_rd,
   input  logic [3:0]         csr_addr,
   input  logic [31:0]        csr_wdata,
   output logic [31:0]        csr_rdata,
   output logic               csr_rdata_vld,
   output logic [AVMM_AW-1:0] avmm_address,
   output logic               avmm_write,
   output logic               avmm_read,
   output logic [31:0]        avmm_writedata,
   input  logic               avmm_waitrequest,
   input  logic [31:0]        avmm_readdata,
   input  logic               avmm_readdatavalid
);

   state_e             state, state_nxt;
   logic [AVMM_AW-1:0] spi_ar;
   logic [31:0]        spi_wr_dr, spi_rd_dr, rdata_c;
   logic               rd_cmd, wr_cmd, err;
   logic               busy_c, tmo_c;
   logic               sel_csr_c, sel_ar_c, sel_wr_dr_c;
   logic               start_rd_c, start_wr_c, wr_done_c, rd_done_c, abort_c;
   logic [1:0]         csr_addr_unused;

   assign csr_addr_unused = csr_addr[1:0];
   assign busy_c          = (state != ST_IDLE);
   assign sel_csr_c       = csr_wr && (csr_addr[3:2] == SPI_CSR_OFS[3:2]);
   assign sel_ar_c        = csr_wr && (csr_addr[3:2] == SPI_AR_OFS[3:2]);
   assign sel_wr_dr_c     = csr_wr && (csr_addr[3:2] == SPI_WR_DR_OFS[3:2]);

   // Read command wins when both command bits arrive together
   assign start_rd_c = sel_csr_c && !busy_c && csr_wdata[CSR_RD_CMD];
   assign start_wr_c = sel_csr_c && !busy_c && csr_wdata[CSR_WR_CMD] && !csr_wdata[CSR_RD_CMD];

   assign avmm_address   = spi_ar;
   assign avmm_writedata = spi_wr_dr;

   // Next state and transaction completion/abort strobes
   always_comb begin
      state_nxt = state;
      wr_done_c = 1'b0;
      rd_done_c = 1'b0;
      abort_c   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_rd_c)      state_nxt = ST_RD;
            else if (start_wr_c) state_nxt = ST_WR;
         end
         ST_WR: begin
            if (tmo_c) begin
               abort_c   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!avmm_waitrequest) begin
               wr_done_c = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_RD: begin
            if (tmo_c) begin
               abort_c   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!avmm_waitrequest) begin
               state_nxt = ST_RDW;
            end
         end
         ST_RDW: begin
            if (tmo_c) begin
               abort_c   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (avmm_readdatavalid) begin
               rd_done_c = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rdata_c = '0;
      case (csr_addr[3:2])
         SPI_CSR_OFS[3:2]: begin
            rdata_c[CSR_RD_CMD] = rd_cmd;
            rdata_c[CSR_WR_CMD] = wr_cmd;
            rdata_c[CSR_ERR]    = err;
            rdata_c[CSR_BUSY]   = busy_c;
         end
         SPI_AR_OFS[3:2]:    rdata_c = 32'(spi_ar);
         SPI_RD_DR_OFS[3:2]: rdata_c = spi_rd_dr;
         SPI_WR_DR_OFS[3:2]: rdata_c = spi_wr_dr;
         default:            rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         avmm_read     <= 1'b0;
         avmm_write    <= 1'b0;
         spi_ar        <= '0;
         spi_wr_dr     <= '0;
         spi_rd_dr     <= '0;
         rd_cmd        <= 1'b0;
         wr_cmd        <= 1'b0;
         csr_rdata     <= '0;
         csr_rdata_vld <= 1'b0;
      end else begin
         state      <= state_nxt;
         avmm_read  <= (state_nxt == ST_RD);
         avmm_write <= (state_nxt == ST_WR);

         // Address and write data stay frozen while a request is in flight
         if (sel_ar_c && !busy_c)    spi_ar    <= csr_wdata[AVMM_AW-1:0];
         if (sel_wr_dr_c && !busy_c) spi_wr_dr <= csr_wdata;

         if (start_rd_c)                  rd_cmd <= 1'b1;
         else if (rd_done_c || abort_c)   rd_cmd <= 1'b0;
         if (start_wr_c)                  wr_cmd <= 1'b1;
         else if (wr_done_c || abort_c)   wr_cmd <= 1'b0;

         if (rd_done_c)                        spi_rd_dr <= avmm_readdata;
         else if (abort_c && state != ST_WR)   spi_rd_dr <= '0;

         csr_rdata_vld <= csr_rd;
         if (csr_rd) csr_rdata <= rdata_c;
      end
   end

`ifdef PMCI_SPI_BRIDGE_TIMEOUT_EN
   pmci_spi_bridge_tmo #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tmo (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     ((state == ST_IDLE) && (state_nxt != ST_IDLE)),
      .run       (busy_c),
      .expired_c (tmo_c)
   );

   // Sticky error; W1C is honoured even while a transaction is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                err <= 1'b0;
      else if (abort_c)                          err <= 1'b1;
      else if (sel_csr_c && csr_wdata[CSR_ERR])  err <= 1'b0;
   end
`else
   // The cycle limit has no effect when the watchdog is compiled out
   logic tmo_cfg_unused;
   assign tmo_cfg_unused = (TIMEOUT_CYC != 0);
   assign tmo_c          = 1'b0;
   assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_pmci_spi_bridge.sv
// Directed self-checking bench for pmci_spi_bridge with a small Avalon-MM slave model.
// Build with PMCI_SPI_BRIDGE_TIMEOUT_EN defined to also exercise the watchdog.
module tb_pmci_spi_bridge;
   import pmci_spi_bridge_pkg::*;

   localparam int unsigned AW = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          csr_wr = 1'b0, csr_rd = 1'b0;
   logic [3:0]    csr_addr = '0;
   logic [31:0]   csr_wdata = '0;
   logic [31:0]   csr_rdata;
   logic          csr_rdata_vld;
   logic [AW-1:0] avmm_address;
   logic          avmm_write, avmm_read;
   logic [31:0]   avmm_writedata;
   logic          avmm_waitrequest;
   logic [31:0]   avmm_readdata;
   logic          avmm_readdatavalid;

   int checks = 0;
   int failures = 0;

   // Slave model knobs and observation counters
   int            wait_cfg = 0;
   int            rd_lat_cfg = 1;
   logic [31:0]   rd_val = '0;
   int            wr_cyc = 0, rd_cyc = 0, wr_req = 0, rd_req = 0, overlap = 0, addr_chg = 0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_data = '0;

   always #5 clk = ~clk;

   pmci_spi_bridge #(
      .AVMM_AW     (AW),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .csr_wr             (csr_wr),
      .csr_rd             (csr_rd),
      .csr_addr           (csr_addr),
      .csr_wdata          (csr_wdata),
      .csr_rdata          (csr_rdata),
      .csr_rdata_vld      (csr_rdata_vld),
      .avmm_address       (avmm_address),
      .avmm_write         (avmm_write),
      .avmm_read          (avmm_read),
      .avmm_writedata     (avmm_writedata),
      .avmm_waitrequest   (avmm_waitrequest),
      .avmm_readdata      (avmm_readdata),
      .avmm_readdatavalid (avmm_readdatavalid)
   );

   // Slave: stalls wait_cfg cycles per request, returns read data rd_lat_cfg cycles after accept
   initial begin : slave
      int   wcnt, rd_left;
      logic rd_pend, prev_wr, prev_rd;
      wcnt = 0; rd_left = 0; rd_pend = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0;
      avmm_waitrequest = 1'b0; avmm_readdata = '0; avmm_readdatavalid = 1'b0;
      forever begin
         @(negedge clk);
         avmm_readdatavalid = 1'b0;
         if (rd_pend) begin
            rd_left--;
            if (rd_left <= 0) begin
               avmm_readdatavalid = 1'b1;
               avmm_readdata      = rd_val;
               rd_pend            = 1'b0;
            end
         end
         if (avmm_read && avmm_write) overlap++;
         if (avmm_write) begin
            wr_cyc++;
            if (!prev_wr) begin
               wr_req++;
               req_addr = avmm_address;
               req_data = avmm_writedata;
            end else if (avmm_address !== req_addr || avmm_writedata !== req_data) begin
               addr_chg++;
            end
         end
         if (avmm_read) begin
            rd_cyc++;
            if (!prev_rd) begin
               rd_req++;
               req_addr = avmm_address;
            end else if (avmm_address !== req_addr) begin
               addr_chg++;
            end
         end
         prev_wr = avmm_write;
         prev_rd = avmm_read;
         if (avmm_read || avmm_write) begin
            if (wcnt < wait_cfg) begin
               avmm_waitrequest = 1'b1;
               wcnt++;
            end else begin
               avmm_waitrequest = 1'b0;
               if (avmm_read) begin
                  rd_pend = 1'b1;
                  rd_left = rd_lat_cfg;
               end
            end
         end else begin
            avmm_waitrequest = 1'b0;
            wcnt = 0;
         end
      end
   end

   task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
      csr_addr  = a;
      csr_wdata = d;
      csr_wr    = 1'b1;
      @(negedge clk);
      csr_wr    = 1'b0;
   endtask

   task automatic csr_read(input logic [3:0] a, output logic [31:0] d, output logic v);
      csr_addr = a;
      csr_rd   = 1'b1;
      @(negedge clk);
      csr_rd   = 1'b0;
      d = csr_rdata;
      v = csr_rdata_vld;
   endtask

   task automatic wait_not_busy(output logic ok);
      logic [31:0] d;
      logic        v;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         csr_read(SPI_CSR_OFS, d, v);
         if (!d[CSR_BUSY]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        v;
      repeat (2) @(negedge clk);
      checks++; if (avmm_write !== 1'b0 || avmm_read !== 1'b0) begin
         failures++; $display("FAIL reset_strobes got wr=%b rd=%b exp 0 0", avmm_write, avmm_read); end
      checks++; if (csr_rdata_vld !== 1'b0 || csr_rdata !== 32'h0) begin
         failures++; $display("FAIL reset_csr_out got vld=%b data=%h exp 0 0", csr_rdata_vld, csr_rdata); end
      rst_n = 1'b1;
      @(negedge clk);
      csr_read(SPI_CSR_OFS, d, v);
      checks++; if (v !== 1'b1 || d !== 32'h0) begin
         failures++; $display("FAIL reset_csr_read got vld=%b data=%h exp 1 0", v, d); end
      @(negedge clk);
      checks++; if (csr_rdata_vld !== 1'b0) begin
         failures++; $display("FAIL rdata_vld_one_cycle got %b exp 0", csr_rdata_vld); end
      csr_read(SPI_AR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL reset_ar got %h exp 0", d); end
   endtask

   task automatic test_write();
      logic [31:0] d;
      logic        v, ok;
      int          wc0, wr0, rc0;
      wait_cfg = 3;
      wc0 = wr_cyc; wr0 = wr_req; rc0 = rd_cyc;
      csr_write(SPI_AR_OFS, 32'h0000_2222);
      csr_write(SPI_WR_DR_OFS, 32'h1111_2222);
      csr_write(SPI_CSR_OFS, 32'h2);
      wait_not_busy(ok);
      checks++; if (ok !== 1'b1) begin
         failures++; $display("FAIL write_timeout got busy exp idle"); end
      checks++; if (wr_cyc - wc0 !== 4 || wr_req - wr0 !== 1) begin
         failures++; $display("FAIL write_len got cyc=%0d req=%0d exp 4 1", wr_cyc - wc0, wr_req - wr0); end
      checks++; if (req_addr !== 20'h02222 || req_data !== 32'h1111_2222) begin
         failures++; $display("FAIL write_payload got a=%h d=%h exp 02222 11112222", req_addr, req_data); end
      checks++; if (addr_chg !== 0 || rd_cyc !== rc0) begin
         failures++; $display("FAIL write_stable got chg=%0d rdcyc=%0d exp 0 %0d", addr_chg, rd_cyc, rc0); end
      csr_read(SPI_CSR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL write_csr_after got %h exp 0", d); end
   endtask

   task automatic test_read();
      logic [31:0] d;
      logic        v, ok;
      int          rr0;
      wait_cfg = 1; rd_lat_cfg = 5; rd_val = 32'hA5A5_5A5A;
      rr0 = rd_req;
      csr_write(SPI_CSR_OFS, 32'h1);
      csr_read(SPI_CSR_OFS, d, v);
      checks++; if (d !== 32'h9) begin
         failures++; $display("FAIL read_busy_rd got %h exp 9", d); end
      repeat (2) @(negedge clk);
      csr_read(SPI_CSR_OFS, d, v);
      checks++; if (d !== 32'h9) begin
         failures++; $display("FAIL read_busy_rdw got %h exp 9", d); end
      wait_not_busy(ok);
      checks++; if (ok !== 1'b1) begin
         failures++; $display("FAIL read_timeout got busy exp idle"); end
      csr_read(SPI_RD_DR_OFS, d, v);
      checks++; if (d !== 32'hA5A5_5A5A) begin
         failures++; $display("FAIL read_data got %h exp a5a55a5a", d); end
      checks++; if (rd_req - rr0 !== 1) begin
         failures++; $display("FAIL read_count got %0d exp 1", rd_req - rr0); end
   endtask

   task automatic test_both_cmds();
      logic [31:0] d;
      logic        v, ok;
      int          rr0, wc0;
      wait_cfg = 2; rd_lat_cfg = 3; rd_val = 32'h0BAD_F00D;
      rr0 = rd_req; wc0 = wr_cyc;
      csr_write(SPI_CSR_OFS, 32'h3);
      wait_not_busy(ok);
      repeat (4) @(negedge clk);
      checks++; if (ok !== 1'b1 || rd_req - rr0 !== 1 || wr_cyc !== wc0) begin
         failures++; $display("FAIL both_cmds got ok=%b rd=%0d wrcyc=%0d exp 1 1 0", ok, rd_req - rr0, wr_cyc - wc0); end
      csr_read(SPI_RD_DR_OFS, d, v);
      checks++; if (d !== 32'h0BAD_F00D) begin
         failures++; $display("FAIL both_data got %h exp 0badf00d", d); end
      csr_read(SPI_CSR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL both_csr got %h exp 0", d); end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] d;
      logic        v, ok;
      int          rr0, wc0;
      wait_cfg = 10;
      rr0 = rd_req; wc0 = wr_cyc;
      csr_write(SPI_CSR_OFS, 32'h2);
      csr_write(SPI_AR_OFS, 32'h0000_FFFF);
      csr_write(SPI_WR_DR_OFS, 32'hDEAD_BEEF);
      csr_write(SPI_CSR_OFS, 32'h1);
      wait_not_busy(ok);
      repeat (5) @(negedge clk);
      checks++; if (ok !== 1'b1 || wr_cyc - wc0 !== 11 || rd_req !== rr0) begin
         failures++; $display("FAIL busy_txn got ok=%b wrcyc=%0d rd=%0d exp 1 11 0", ok, wr_cyc - wc0, rd_req - rr0); end
      checks++; if (addr_chg !== 0 || req_data !== 32'h1111_2222) begin
         failures++; $display("FAIL busy_stable got chg=%0d d=%h exp 0 11112222", addr_chg, req_data); end
      csr_read(SPI_AR_OFS, d, v);
      checks++; if (d !== 32'h0000_2222) begin
         failures++; $display("FAIL busy_ar got %h exp 2222", d); end
      csr_read(SPI_WR_DR_OFS, d, v);
      checks++; if (d !== 32'h1111_2222) begin
         failures++; $display("FAIL busy_wr_dr got %h exp 11112222", d); end
      wait_cfg = 0;
   endtask

   task automatic test_addr_mask();
      logic [31:0] d;
      logic        v;
      csr_write(SPI_AR_OFS, 32'hFFFF_FFFF);
      csr_read(SPI_AR_OFS, d, v);
      checks++; if (d !== 32'h000F_FFFF) begin
         failures++; $display("FAIL ar_mask got %h exp 000fffff", d); end
   endtask

`ifdef PMCI_SPI_BRIDGE_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] d;
      logic        v, ok;
      int          rc0;
      wait_cfg = 1000;
      rc0 = rd_cyc;
      csr_write(SPI_CSR_OFS, 32'h1);
      wait_not_busy(ok);
      checks++; if (ok !== 1'b1 || rd_cyc - rc0 !== 16) begin
         failures++; $display("FAIL tmo_len got ok=%b cyc=%0d exp 1 16", ok, rd_cyc - rc0); end
      csr_read(SPI_CSR_OFS, d, v);
      checks++; if (d !== 32'h4) begin
         failures++; $display("FAIL tmo_err got %h exp 4", d); end
      csr_read(SPI_RD_DR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL tmo_rd_dr got %h exp 0", d); end
      csr_write(SPI_CSR_OFS, 32'h4);
      csr_read(SPI_CSR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL tmo_w1c got %h exp 0", d); end
      wait_cfg = 0;
   endtask
`endif

   task automatic test_reset_rdw();
      logic [31:0] d;
      logic        v;
      int          rc0, wc0;
      wait_cfg = 0; rd_lat_cfg = 8; rd_val = 32'h1234_5678;
      csr_write(SPI_CSR_OFS, 32'h1);
      csr_read(SPI_CSR_OFS, d, v);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (avmm_read !== 1'b0 || avmm_write !== 1'b0 || csr_rdata !== 32'h0 || csr_rdata_vld !== 1'b0) begin
         failures++; $display("FAIL async_reset got rd=%b wr=%b data=%h vld=%b exp 0 0 0 0",
                              avmm_read, avmm_write, csr_rdata, csr_rdata_vld); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rc0 = rd_cyc; wc0 = wr_cyc;
      repeat (15) @(negedge clk);
      checks++; if (rd_cyc !== rc0 || wr_cyc !== wc0) begin
         failures++; $display("FAIL stray_strobe got rd=%0d wr=%0d exp 0 0", rd_cyc - rc0, wr_cyc - wc0); end
      csr_read(SPI_AR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL rst_ar got %h exp 0", d); end
      csr_read(SPI_WR_DR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL rst_wr_dr got %h exp 0", d); end
      csr_read(SPI_RD_DR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL rst_rd_dr got %h exp 0", d); end
      csr_read(SPI_CSR_OFS, d, v);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL rst_csr got %h exp 0", d); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_both_cmds();
      test_busy_ignore();
      test_addr_mask();
`ifdef PMCI_SPI_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_rdw();
      checks++; if (overlap !== 0) begin
         failures++; $display("FAIL rd_wr_overlap got %0d exp 0", overlap); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "bench timed out");
   end

endmodule

// File: doc/pmci_spi_bridge.md
PMCI_SPI_BRIDGE -- requirements
Module: pmci_spi_bridge

Interface
REQ-001 The block SHALL have parameter AVMM_AW, default 20, meaning downstream Avalon-MM address width; SPI_AR writable bits are [AVMM_AW-1:0].
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the cycle limit for one downstream transaction.
REQ-003 The block SHALL have port clk, input, 1, sole clock.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have CSR ports csr_wr (in, 1), csr_rd (in, 1), csr_addr (in, 4, byte offset; [3:2] decoded), csr_wdata (in, 32), csr_rdata (out, 32) and csr_rdata_vld (out, 1).
REQ-006 The block SHALL have Avalon-MM master ports avmm_address (out, AVMM_AW), avmm_write (out, 1), avmm_read (out, 1), avmm_writedata (out, 32), avmm_waitrequest (in, 1), avmm_readdata (in, 32) and avmm_readdatavalid (in, 1).

Function
REQ-007 Register map SHALL be: 0x0 SPI_CSR, 0x4 SPI_AR (RW), 0x8 SPI_RD_DR (RO), 0xC SPI_WR_DR (RW, 32-bit).
REQ-008 SPI_CSR bit layout SHALL be: bit0 RD_CMD (W1S, self-clearing), bit1 WR_CMD (W1S, self-clearing), bit2 ERR (sticky, W1C), bit3 BUSY (RO); all other bits read 0.
REQ-009 CSR reads SHALL return csr_rdata with csr_rdata_vld high exactly 1 cycle after csr_rd; writes SHALL take effect on the next edge.
REQ-010 The FSM SHALL have states IDLE, WR, RD and RDW; BUSY = (state != IDLE).
REQ-011 IDLE SHALL go to RD on a CSR write setting bit0, and to WR on a CSR write setting bit1; if both bits are set in one write, RD wins and WR_CMD is discarded.
REQ-012 In WR, avmm_write SHALL be held with address=SPI_AR and writedata=SPI_WR_DR; the first cycle with !avmm_waitrequest goes to IDLE and clears WR_CMD.
REQ-013 In RD, avmm_read SHALL be held; the first cycle with !avmm_waitrequest goes to RDW.
REQ-014 In RDW, avmm_readdatavalid SHALL load SPI_RD_DR, clear RD_CMD and go to IDLE.
REQ-015 avmm_address and avmm_writedata SHALL be stable for the whole request.
REQ-016 avmm_read and avmm_write SHALL never be asserted together.
REQ-017 While BUSY, CSR writes to SPI_AR, SPI_WR_DR and the command bits SHALL be ignored; an ERR W1C write SHALL still be honoured.
REQ-018 A CSR read SHALL be serviced in every state, including while BUSY.
REQ-019 avmm_readdatavalid outside RDW SHALL be ignored.

Reset
REQ-020 On rst_n low, asynchronously: state=IDLE, all registers=0, avmm_read/avmm_write=0, csr_rdata=0, csr_rdata_vld=0.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no further downstream strobes.

Configuration
REQ-022 With PMCI_SPI_BRIDGE_TIMEOUT_EN defined, a counter SHALL clear on entry to WR or RD and increment in WR/RD/RDW.
REQ-023 When that counter reaches TIMEOUT_CYC-1, the block SHALL drop strobes, go to IDLE, set ERR, clear both command bits and load SPI_RD_DR=0 on a read.
REQ-024 Without PMCI_SPI_BRIDGE_TIMEOUT_EN, no counter SHALL exist, ERR SHALL read 0, and the FSM SHALL wait indefinitely.

Structure
REQ-025 Package pmci_spi_bridge_pkg SHALL hold the register offset constants, the SPI_CSR bit index constants and the FSM state enum.
REQ-026 Register decode and the FSM SHALL stay in one module; sub-module pmci_spi_bridge_tmo (timeout counter) SHALL be instantiated only under the macro.

Verification
REQ-027 Scenario: write SPI_AR=0x2222, SPI_WR_DR=0x1111_2222, SPI_CSR=0x2 with waitrequest high for 3 cycles -> avmm_write held 4 cycles with address 0x2222 and data 0x11112222; SPI_CSR then reads 0x0.
REQ-028 Scenario: SPI_CSR=0x1 with slave returning 0xA5A5_5A5A 5 cycles after accept -> SPI_RD_DR reads 0xA5A55A5A; BUSY reads 1 during the wait.
REQ-029 Scenario: SPI_CSR=0x3 -> exactly one avmm_read and no avmm_write.
REQ-030 Scenario: write SPI_AR=0xFFFF while BUSY -> SPI_AR retains its prior value.
REQ-031 Scenario (macro on, TIMEOUT_CYC=16): read with waitrequest stuck high -> strobe drops after 16 cycles, SPI_CSR reads 0x4; writing 0x4 clears it.
REQ-032 Scenario: assert rst_n low during RDW, then release -> all registers read 0 and no stray strobe occurs.
